// File: rtl/doodle_pkg.sv
// doodle_pkg -- shared constants and helpers for the doodle motion block.
//   Screen bounds, doodle radius, the one-hot jump-state encodings driven by
//   the doodle state machine, the decoded motion phase enum, and two small
//   helper functions (phase decode and saturating 10-bit add).
package doodle_pkg;

  // Visible screen area in pixels.
  localparam int unsigned SCREEN_X_MIN  = 144;
  localparam int unsigned SCREEN_X_MAX  = 774;
  localparam int unsigned SCREEN_Y_MIN  = 35;
  localparam int unsigned SCREEN_Y_MAX  = 515;
  localparam int unsigned DOODLE_RADIUS = 13;

  // One-hot jump-state encodings, ordered {q_I, q_Up, q_Down, q_Done}.
  localparam logic [3:0] ST_IDLE = 4'b1000;
  localparam logic [3:0] ST_UP   = 4'b0100;
  localparam logic [3:0] ST_DOWN = 4'b0010;
  localparam logic [3:0] ST_DONE = 4'b0001;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_RISE = 2'd1,
    PH_FALL = 2'd2,
    PH_HALT = 2'd3
  } phase_e;

  // Anything that is not a clean one-hot state is treated as HALT so that a
  // glitching state machine freezes the doodle instead of moving it.
  function automatic phase_e decode_phase(input logic [3:0] st);
    phase_e ph;
    case (st)
      ST_IDLE: ph = PH_IDLE;
      ST_UP:   ph = PH_RISE;
      ST_DOWN: ph = PH_FALL;
      ST_DONE: ph = PH_HALT;
      default: ph = PH_HALT;
    endcase
    return ph;
  endfunction

  // Distance counters stop at 1023 rather than wrapping back to 0.
  function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [3:0] b);
    logic [10:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    if (sum[10]) begin
      return 10'h3FF;
    end else begin
      return sum[9:0];
    end
  endfunction

endpackage

// File: rtl/doodle_tick.sv
// doodle_tick -- motion tick generator.
//   Free-running counter 0..TICK_DIV-1; tick is high for the one cycle in
//   which the count equals TICK_DIV-1. While enable is low the counter is
//   held at 0, so the first tick after enabling comes TICK_DIV cycles later.
// Ports:
//   Clk     in  1  system clock
//   Reset_n in  1  synchronous active-low reset
//   enable  in  1  counter runs when high, held at 0 when low
//   tick    out 1  one-cycle motion pulse
module doodle_tick #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next-count: hold at zero when disabled, wrap after the last count.
  always_comb begin
    count_d = count_q;
    if (!enable) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/doodle_motion.sv
// doodle_motion -- doodle position and vertical-speed tracker.
//   Moves the doodle once per motion tick according to the jump phase from
//   the doodle state machine: rises with apex easing, falls with easing out
//   of the apex, steps horizontally with screen wrap, freezes on HALT and
//   reloads the start position while IDLE. All outputs are registered.
// Ports:
//   Clk, Reset_n                   clock, synchronous active-low reset
//   q_I, q_Up, q_Down, q_Done      one-hot jump state
//   JUMP_HEIGHT [9:0]              jump apex distance
//   is_in_middle                   screen scrolling: hold screen y on rise
//   move_left, move_right          debounced buttons
//   up_count [9:0]                 distance risen in this jump
//   object_x, object_y [15:0]      screen position
//   true_y [15:0]                  world y (two's complement)
//   vert_speed [3:0]               current vertical step
module doodle_motion
  import doodle_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned START_X   = 459,
  parameter int unsigned START_Y   = 400,
  parameter int unsigned MAX_SPEED = 4,
  parameter int unsigned MIN_SPEED = 1,
  parameter int unsigned SLOW_ZONE = 40,
  parameter int unsigned H_SPEED   = 2,
  parameter int unsigned X_MIN     = 157,
  parameter int unsigned X_MAX     = 761
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        q_I,
  input  logic        q_Up,
  input  logic        q_Down,
  input  logic        q_Done,
  input  logic [9:0]  JUMP_HEIGHT,
  input  logic        is_in_middle,
  input  logic        move_left,
  input  logic        move_right,
  output logic [9:0]  up_count,
  output logic [15:0] object_x,
  output logic [15:0] object_y,
  output logic [15:0] true_y,
  output logic [3:0]  vert_speed
);

  localparam logic [15:0] START_X_V = 16'(START_X);
  localparam logic [15:0] START_Y_V = 16'(START_Y);
  localparam logic [3:0]  MAX_SPD_V = 4'(MAX_SPEED);
  localparam logic [3:0]  MIN_SPD_V = 4'(MIN_SPEED);

  logic [9:0]  up_count_q,   up_count_d;
  logic [9:0]  down_count_q, down_count_d;
  logic [15:0] object_x_q,   object_x_d;
  logic [15:0] object_y_q,   object_y_d;
  logic [15:0] true_y_q,     true_y_d;
  logic [3:0]  vert_speed_q, vert_speed_d;
  logic        up_prev_q,    down_prev_q;

  logic        tick_s;
  logic        tick_en_s;
  phase_e      phase_s;
  logic        rise_entry_s;
  logic        fall_entry_s;
  logic [10:0] rise_cmp_s;
  logic [3:0]  rise_speed_s;
  logic [3:0]  fall_speed_s;
  logic [16:0] x_left_s;
  logic [16:0] x_right_s;
  logic [15:0] x_step_s;

  // Tick counter idles at 0 outside a jump so each jump starts on a fresh period.
  assign tick_en_s = ~(q_I | q_Done);

  doodle_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .enable  (tick_en_s),
    .tick    (tick_s)
  );

  assign phase_s      = decode_phase({q_I, q_Up, q_Down, q_Done});
  assign rise_entry_s = q_Up & ~up_prev_q;
  assign fall_entry_s = q_Down & ~down_prev_q;

  // Apex easing: slow down for the last SLOW_ZONE pixels of the rise and the
  // first SLOW_ZONE pixels of the fall. Rise compare is 11 bits to avoid wrap.
  always_comb begin
    rise_cmp_s = {1'b0, up_count_q} + 11'(SLOW_ZONE);
    if (rise_cmp_s < {1'b0, JUMP_HEIGHT}) begin
      rise_speed_s = MAX_SPD_V;
    end else begin
      rise_speed_s = MIN_SPD_V;
    end
    if (32'(down_count_q) < 32'(SLOW_ZONE)) begin
      fall_speed_s = MIN_SPD_V;
    end else begin
      fall_speed_s = MAX_SPD_V;
    end
  end

  // Horizontal step with wrap to the opposite edge; 17-bit math catches underflow.
  always_comb begin
    x_left_s  = {1'b0, object_x_q} - 17'(H_SPEED);
    x_right_s = {1'b0, object_x_q} + 17'(H_SPEED);
    x_step_s  = object_x_q;
    if (move_left && !move_right) begin
      if (x_left_s[16] || (x_left_s < 17'(X_MIN))) begin
        x_step_s = 16'(X_MAX);
      end else begin
        x_step_s = x_left_s[15:0];
      end
    end else if (move_right && !move_left) begin
      if (x_right_s > 17'(X_MAX)) begin
        x_step_s = 16'(X_MIN);
      end else begin
        x_step_s = x_right_s[15:0];
      end
    end else begin
      x_step_s = object_x_q;
    end
  end

  // Next-state for position, counters and speed by phase.
  always_comb begin
    up_count_d   = up_count_q;
    down_count_d = down_count_q;
    object_x_d   = object_x_q;
    object_y_d   = object_y_q;
    true_y_d     = true_y_q;
    vert_speed_d = vert_speed_q;
    case (phase_s)
      PH_IDLE: begin
        up_count_d   = 10'd0;
        down_count_d = 10'd0;
        object_x_d   = START_X_V;
        object_y_d   = START_Y_V;
        true_y_d     = START_Y_V;
        vert_speed_d = MAX_SPD_V;
      end
      PH_RISE: begin
        vert_speed_d = rise_speed_s;
        // Entry cycle wins over a coincident tick: the tick is swallowed.
        if (rise_entry_s) begin
          up_count_d = 10'd0;
        end else if (tick_s) begin
          up_count_d = sat_add10(up_count_q, rise_speed_s);
          true_y_d   = true_y_q - {12'd0, rise_speed_s};
          object_x_d = x_step_s;
          if (!is_in_middle) begin
            object_y_d = object_y_q - {12'd0, rise_speed_s};
          end else begin
            object_y_d = object_y_q;
          end
        end else begin
          up_count_d = up_count_q;
        end
      end
      PH_FALL: begin
        vert_speed_d = fall_speed_s;
        if (fall_entry_s) begin
          down_count_d = 10'd0;
        end else if (tick_s) begin
          down_count_d = sat_add10(down_count_q, fall_speed_s);
          object_y_d   = object_y_q + {12'd0, fall_speed_s};
          true_y_d     = true_y_q + {12'd0, fall_speed_s};
          object_x_d   = x_step_s;
        end else begin
          down_count_d = down_count_q;
        end
      end
      PH_HALT: begin
        vert_speed_d = vert_speed_q;
      end
      default: begin
        vert_speed_d = vert_speed_q;
      end
    endcase
  end

  // State registers; reset reloads the idle values regardless of phase.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      up_count_q   <= 10'd0;
      down_count_q <= 10'd0;
      object_x_q   <= START_X_V;
      object_y_q   <= START_Y_V;
      true_y_q     <= START_Y_V;
      vert_speed_q <= MAX_SPD_V;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
    end else begin
      up_count_q   <= up_count_d;
      down_count_q <= down_count_d;
      object_x_q   <= object_x_d;
      object_y_q   <= object_y_d;
      true_y_q     <= true_y_d;
      vert_speed_q <= vert_speed_d;
      up_prev_q    <= q_Up;
      down_prev_q  <= q_Down;
    end
  end

  assign up_count   = up_count_q;
  assign object_x   = object_x_q;
  assign object_y   = object_y_q;
  assign true_y     = true_y_q;
  assign vert_speed = vert_speed_q;

endmodule

// File: tb/tb_doodle_motion.sv
// tb_doodle_motion -- directed bench for doodle_motion with TICK_DIV=4 and
// JUMP_HEIGHT=100. A second instance starts at x=158 to reach the left wrap.
module tb_doodle_motion;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        q_I, q_Up, q_Down, q_Done;
  logic [9:0]  JUMP_HEIGHT;
  logic        is_in_middle, move_left, move_right;

  logic [9:0]  up_count,   up_count_x;
  logic [15:0] object_x,   object_x_x;
  logic [15:0] object_y,   object_y_x;
  logic [15:0] true_y,     true_y_x;
  logic [3:0]  vert_speed, vert_speed_x;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  doodle_motion #(.TICK_DIV(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
    .JUMP_HEIGHT(JUMP_HEIGHT), .is_in_middle(is_in_middle),
    .move_left(move_left), .move_right(move_right),
    .up_count(up_count), .object_x(object_x), .object_y(object_y),
    .true_y(true_y), .vert_speed(vert_speed)
  );

  doodle_motion #(.TICK_DIV(4), .START_X(158)) dut_x (
    .Clk(Clk), .Reset_n(Reset_n),
    .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
    .JUMP_HEIGHT(JUMP_HEIGHT), .is_in_middle(is_in_middle),
    .move_left(move_left), .move_right(move_right),
    .up_count(up_count_x), .object_x(object_x_x), .object_y(object_y_x),
    .true_y(true_y_x), .vert_speed(vert_speed_x)
  );

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic go_idle();
    q_I = 1'b1; q_Up = 1'b0; q_Down = 1'b0; q_Done = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    go_idle();
    checks++; if (object_x !== 16'd459) begin errors++; $display("FAIL rst_x got %0d want 459", object_x); end
    checks++; if (object_y !== 16'd400) begin errors++; $display("FAIL rst_y got %0d want 400", object_y); end
    checks++; if (vert_speed !== 4'd4) begin errors++; $display("FAIL rst_speed got %0d want 4", vert_speed); end
    Reset_n = 1'b1;
    q_I = 1'b0; q_Up = 1'b1;
    step(8);
    checks++; if (up_count !== 10'd8) begin errors++; $display("FAIL pre_rst_up got %0d want 8", up_count); end
    checks++; if (object_y !== 16'd392) begin errors++; $display("FAIL pre_rst_y got %0d want 392", object_y); end
    Reset_n = 1'b0;
    step(1);
    checks++; if (object_x !== 16'd459) begin errors++; $display("FAIL midrst_x got %0d want 459", object_x); end
    checks++; if (object_y !== 16'd400) begin errors++; $display("FAIL midrst_y got %0d want 400", object_y); end
    checks++; if (true_y !== 16'd400) begin errors++; $display("FAIL midrst_ty got %0d want 400", true_y); end
    checks++; if (up_count !== 10'd0) begin errors++; $display("FAIL midrst_up got %0d want 0", up_count); end
    checks++; if (vert_speed !== 4'd4) begin errors++; $display("FAIL midrst_speed got %0d want 4", vert_speed); end
    step(1);
    Reset_n = 1'b1;
    go_idle();
  endtask

  task automatic test_rise();
    q_I = 1'b0; q_Up = 1'b1;
    step(3);
    checks++; if (object_y !== 16'd400) begin errors++; $display("FAIL rise_pretick_y got %0d want 400", object_y); end
    step(57);
    checks++; if (up_count !== 10'd60) begin errors++; $display("FAIL rise15_up got %0d want 60", up_count); end
    checks++; if (object_y !== 16'd340) begin errors++; $display("FAIL rise15_y got %0d want 340", object_y); end
    checks++; if (true_y !== 16'd340) begin errors++; $display("FAIL rise15_ty got %0d want 340", true_y); end
    step(1);
    checks++; if (vert_speed !== 4'd1) begin errors++; $display("FAIL rise_ease_speed got %0d want 1", vert_speed); end
    step(3);
    checks++; if (up_count !== 10'd61) begin errors++; $display("FAIL rise16_up got %0d want 61", up_count); end
    step(16);
    checks++; if (up_count !== 10'd65) begin errors++; $display("FAIL rise20_up got %0d want 65", up_count); end
    checks++; if (object_y !== 16'd335) begin errors++; $display("FAIL rise20_y got %0d want 335", object_y); end
    go_idle();
    checks++; if (object_y !== 16'd400) begin errors++; $display("FAIL idle_reload_y got %0d want 400", object_y); end
  endtask

  task automatic test_middle();
    is_in_middle = 1'b1;
    q_I = 1'b0; q_Up = 1'b1;
    step(20);
    checks++; if (object_y !== 16'd400) begin errors++; $display("FAIL mid_y got %0d want 400", object_y); end
    checks++; if (true_y !== 16'd380) begin errors++; $display("FAIL mid_ty got %0d want 380", true_y); end
    checks++; if (up_count !== 10'd20) begin errors++; $display("FAIL mid_up got %0d want 20", up_count); end
    is_in_middle = 1'b0;
    go_idle();
  endtask

  task automatic test_wrap();
    q_I = 1'b0; q_Up = 1'b1; move_left = 1'b1;
    step(4);
    checks++; if (object_x_x !== 16'd761) begin errors++; $display("FAIL wrap_left got %0d want 761", object_x_x); end
    checks++; if (object_x !== 16'd457) begin errors++; $display("FAIL step_left got %0d want 457", object_x); end
    move_right = 1'b1;
    step(4);
    checks++; if (object_x_x !== 16'd761) begin errors++; $display("FAIL both_hold got %0d want 761", object_x_x); end
    checks++; if (object_x !== 16'd457) begin errors++; $display("FAIL both_hold_main got %0d want 457", object_x); end
    move_left = 1'b0;
    step(4);
    checks++; if (object_x_x !== 16'd157) begin errors++; $display("FAIL wrap_right got %0d want 157", object_x_x); end
    checks++; if (object_x !== 16'd459) begin errors++; $display("FAIL step_right got %0d want 459", object_x); end
    move_right = 1'b0;
    go_idle();
  endtask

  task automatic test_back_to_back();
    q_I = 1'b0; q_Down = 1'b1;
    step(4);
    checks++; if (object_y !== 16'd401) begin errors++; $display("FAIL fall_y got %0d want 401", object_y); end
    checks++; if (true_y !== 16'd401) begin errors++; $display("FAIL fall_ty got %0d want 401", true_y); end
    checks++; if (vert_speed !== 4'd1) begin errors++; $display("FAIL fall_speed got %0d want 1", vert_speed); end
    step(3);
    q_Down = 1'b0; q_Up = 1'b1;
    step(1);
    checks++; if (up_count !== 10'd0) begin errors++; $display("FAIL b2b_up got %0d want 0", up_count); end
    checks++; if (object_y !== 16'd401) begin errors++; $display("FAIL b2b_y got %0d want 401", object_y); end
    checks++; if (true_y !== 16'd401) begin errors++; $display("FAIL b2b_ty got %0d want 401", true_y); end
    step(4);
    checks++; if (up_count !== 10'd4) begin errors++; $display("FAIL b2b_next_up got %0d want 4", up_count); end
    checks++; if (object_y !== 16'd397) begin errors++; $display("FAIL b2b_next_y got %0d want 397", object_y); end
  endtask

  // Continues from the rise left by test_back_to_back: up=4, y=true_y=397.
  task automatic test_halt();
    q_Up = 1'b0; q_Down = 1'b1; q_Done = 1'b1;
    step(200);
    checks++; if (object_y !== 16'd397) begin errors++; $display("FAIL halt_bad_y got %0d want 397", object_y); end
    checks++; if (true_y !== 16'd397) begin errors++; $display("FAIL halt_bad_ty got %0d want 397", true_y); end
    checks++; if (up_count !== 10'd4) begin errors++; $display("FAIL halt_bad_up got %0d want 4", up_count); end
    checks++; if (vert_speed !== 4'd4) begin errors++; $display("FAIL halt_bad_speed got %0d want 4", vert_speed); end
    q_Down = 1'b0;
    step(200);
    checks++; if (object_y !== 16'd397) begin errors++; $display("FAIL halt_done_y got %0d want 397", object_y); end
    checks++; if (object_x !== 16'd459) begin errors++; $display("FAIL halt_done_x got %0d want 459", object_x); end
    checks++; if (up_count !== 10'd4) begin errors++; $display("FAIL halt_done_up got %0d want 4", up_count); end
    go_idle();
  endtask

  initial begin
    Reset_n = 1'b0;
    q_I = 1'b1; q_Up = 1'b0; q_Down = 1'b0; q_Done = 1'b0;
    JUMP_HEIGHT = 10'd100;
    is_in_middle = 1'b0; move_left = 1'b0; move_right = 1'b0;
    test_reset();
    test_rise();
    test_middle();
    test_wrap();
    test_back_to_back();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
